// File: rtl/i_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i_cache_pkg
// Description : Shared definitions for the direct-mapped instruction cache:
//               FSM state encoding, line geometry and address field positions.
// Revision    : 1.0 - initial release
// ============================================================================
package i_cache_pkg;

  // One cache line: 16 bytes = four 32-bit words.
  localparam int LINE_WIDTH     = 128;

  // Fetch-address field positions (byte address).
  localparam int OFFSET_LSB     = 0;   // byte-in-line offset starts here
  localparam int WORD_SEL_LSB   = 2;   // word select = addr[3:2]
  localparam int WORD_SEL_WIDTH = 2;
  localparam int INDEX_LSB      = 4;   // index = addr[9:4]
  localparam int TAG_LSB        = 10;  // tag = addr[31:10]

  // Controller states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    RESUME = 2'd2
  } state_t;

endpackage : i_cache_pkg
`default_nettype wire

// File: rtl/i_cache_array.sv
`default_nettype none
// ============================================================================
// Module      : i_cache_array
// Description : Valid / tag / line storage for the instruction cache.
//               Asynchronous read port, synchronous write port, and a flush
//               input that clears every valid bit on the next rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module i_cache_array #(
  parameter int INDEX_WIDTH = 6,
  parameter int TAG_WIDTH   = 22,
  parameter int LINE_WIDTH  = 128
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  // read port
  input  logic [INDEX_WIDTH-1:0] rd_index,
  output logic                   rd_valid,
  output logic [TAG_WIDTH-1:0]   rd_tag,
  output logic [LINE_WIDTH-1:0]  rd_line,
  // write port
  input  logic                   wr_en,
  input  logic [INDEX_WIDTH-1:0] wr_index,
  input  logic [TAG_WIDTH-1:0]   wr_tag,
  input  logic [LINE_WIDTH-1:0]  wr_line,
  input  logic                   wr_valid
);

  localparam int DEPTH = 1 << INDEX_WIDTH;

  logic [DEPTH-1:0]      valid_q;
  logic [TAG_WIDTH-1:0]  tag_mem  [DEPTH];
  logic [LINE_WIDTH-1:0] line_mem [DEPTH];

  // Valid bits: flush wipes all of them; a same-cycle write then decides the
  // written entry (the write wins so a flushed fill can land with valid=0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      if (flush) begin
        valid_q <= '0;
      end
      if (wr_en) begin
        valid_q[wr_index] <= wr_valid;
      end
    end
  end

  // Tag and data arrays carry no reset; they are only trusted behind valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      line_mem[wr_index] <= wr_line;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_line  = line_mem[rd_index];

endmodule : i_cache_array
`default_nettype wire

// File: rtl/i_cache.sv
`default_nettype none
// ============================================================================
// Module      : i_cache
// Description : Direct-mapped instruction cache, 64 lines x 16 B. Hits are
//               served combinationally; a miss stalls the fetch, fills the
//               line from memory (REFILL), spends one RESUME cycle, then
//               re-looks-up in IDLE. flush_i invalidates every line.
//               Optional feature macro: ICACHE_STATS_EN (hit/miss counters).
// Revision    : 1.0 - initial release
// ============================================================================
module i_cache
  import i_cache_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int SELECT_WIDTH = 4,
  parameter int INDEX_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // fetch side
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic [DATA_WIDTH-1:0] if_inst_o,
  output logic                  if_stall_o,
  input  logic                  flush_i,
  // memory side
  output logic                  mem_read_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [LINE_WIDTH-1:0] mem_data_i,
  input  logic                  mem_done_i,
  // statistics
  output logic [31:0]           hit_cnt_o,
  output logic [31:0]           miss_cnt_o
);

  localparam int TAG_WIDTH = ADDR_WIDTH - TAG_LSB;
  localparam int WORDS     = LINE_WIDTH / DATA_WIDTH;

  state_t state;
  state_t state_next;

  logic [TAG_WIDTH-1:0]      req_tag;
  logic [INDEX_WIDTH-1:0]    req_index;
  logic [WORD_SEL_WIDTH-1:0] req_word;

  logic                      rd_valid;
  logic [TAG_WIDTH-1:0]      rd_tag;
  logic [LINE_WIDTH-1:0]     rd_line;
  logic [DATA_WIDTH-1:0]     line_words [WORDS];

  logic [TAG_WIDTH-1:0]      fill_tag;
  logic [INDEX_WIDTH-1:0]    fill_index;
  logic                      fill_flushed;

  logic                      lookup_hit;
  logic                      start_fill;
  logic                      fill_done;
  logic                      unused_addr_bits;

  // Address decode; the byte-within-word bits play no part in a fetch.
  assign req_word         = if_addr_i[WORD_SEL_LSB +: WORD_SEL_WIDTH];
  assign req_index        = if_addr_i[INDEX_LSB +: INDEX_WIDTH];
  assign req_tag          = if_addr_i[TAG_LSB +: TAG_WIDTH];
  assign unused_addr_bits = ^if_addr_i[OFFSET_LSB +: WORD_SEL_LSB];

  i_cache_array #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .TAG_WIDTH   (TAG_WIDTH),
    .LINE_WIDTH  (LINE_WIDTH)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush_i),
    .rd_index (req_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .wr_en    (fill_done),
    .wr_index (fill_index),
    .wr_tag   (fill_tag),
    .wr_line  (mem_data_i),
    .wr_valid (~(fill_flushed | flush_i))
  );

  // Split the line into addressable words.
  for (genvar k = 0; k < WORDS; k++) begin : g_words
    assign line_words[k] = rd_line[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // A flush in the same cycle forces a miss, so the stale line is never used.
  assign lookup_hit = (state == IDLE) && if_req_i && !flush_i &&
                      rd_valid && (rd_tag == req_tag);
  assign start_fill = (state == IDLE) && if_req_i && !lookup_hit;
  assign fill_done  = (state == REFILL) && mem_done_i;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; stray mem_done_i outside REFILL has no effect.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_fill) state_next = REFILL;
      REFILL:  if (mem_done_i) state_next = RESUME;
      RESUME:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the missing line's tag/index; remember a flush seen mid-fill so
  // the line lands invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_tag     <= '0;
      fill_index   <= '0;
      fill_flushed <= 1'b0;
    end else begin
      if (start_fill) begin
        fill_tag     <= req_tag;
        fill_index   <= req_index;
        fill_flushed <= 1'b0;
      end else if ((state == REFILL) && flush_i) begin
        fill_flushed <= 1'b1;
      end
    end
  end

  // Outputs. Stall is gated by reset so it reads 0 while rst_n is low even
  // with a request pending.
  assign if_inst_o  = lookup_hit ? line_words[req_word] : '0;
  assign if_stall_o = rst_n && ((state != IDLE) || start_fill);
  assign mem_read_o = (state == REFILL);
  assign mem_addr_o = {fill_tag, fill_index, {SELECT_WIDTH{1'b0}}};

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  // Count served hits and IDLE->REFILL transitions; both wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (lookup_hit) hit_cnt  <= hit_cnt + 32'd1;
      if (start_fill) miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt;
  assign miss_cnt_o = miss_cnt;
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif

endmodule : i_cache
`default_nettype wire

// File: tb/tb_i_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_i_cache
// Description : Self-checking bench for i_cache. A cache model (arrays of
//               valid/tag/line plus a fill-in-progress record) predicts the
//               outputs every cycle; directed sequences add literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i_cache;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         if_req_i;
  logic [31:0]  if_addr_i;
  logic [31:0]  if_inst_o;
  logic         if_stall_o;
  logic         flush_i;
  logic         mem_read_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_data_i;
  logic         mem_done_i;
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;

  int n_checks = 0;
  int n_pass   = 0;
  int stall_cycles = 0;

  i_cache dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_inst_o  (if_inst_o),
    .if_stall_o (if_stall_o),
    .flush_i    (flush_i),
    .mem_read_o (mem_read_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_i (mem_data_i),
    .mem_done_i (mem_done_i),
    .hit_cnt_o  (hit_cnt_o),
    .miss_cnt_o (miss_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  localparam int P_IDLE = 0, P_WAIT_MEM = 1, P_RESUME = 2;
  int           m_phase;
  bit           mv [64];
  logic [21:0]  mt [64];
  logic [127:0] ml [64];
  logic [31:0]  m_fill_addr;
  bit           m_fill_flushed;
  logic [31:0]  m_hits, m_misses;

  initial begin : compare
    logic [5:0]  idx;
    logic [21:0] tg;
    logic [1:0]  w;
    logic [5:0]  fidx;
    bit          hit, stall;
    logic [31:0] exp_h, exp_m, word;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_phase = P_IDLE;
        for (int i = 0; i < 64; i++) mv[i] = 1'b0;
        m_fill_addr = '0; m_fill_flushed = 1'b0;
        m_hits = '0; m_misses = '0;
        chk("m_rst_stall", if_stall_o, 0);
        chk("m_rst_inst",  if_inst_o, 0);
        chk("m_rst_read",  mem_read_o, 0);
        chk("m_rst_addr",  mem_addr_o, 0);
        chk("m_rst_hitcnt", hit_cnt_o, 0);
        chk("m_rst_misscnt", miss_cnt_o, 0);
      end else begin
        idx = if_addr_i[9:4]; tg = if_addr_i[31:10]; w = if_addr_i[3:2];
        hit = (m_phase == P_IDLE) && if_req_i && !flush_i && mv[idx] && (mt[idx] == tg);
        stall = (m_phase != P_IDLE) || (if_req_i && !hit);
        if (stall) stall_cycles++;
        chk("m_stall", if_stall_o, stall);
        if (!stall) begin
          word = ml[idx] >> (32 * w);
          chk("m_inst", if_inst_o, hit ? word : 32'h0);
        end
        chk("m_read", mem_read_o, m_phase == P_WAIT_MEM);
        if (m_phase == P_WAIT_MEM) chk("m_addr", mem_addr_o, m_fill_addr);
`ifdef ICACHE_STATS_EN
        exp_h = m_hits; exp_m = m_misses;
`else
        exp_h = 0; exp_m = 0;
`endif
        chk("m_hitcnt", hit_cnt_o, exp_h);
        chk("m_misscnt", miss_cnt_o, exp_m);
        // advance model across the coming rising edge
        if (flush_i) for (int i = 0; i < 64; i++) mv[i] = 1'b0;
        case (m_phase)
          P_IDLE: begin
            if (hit) m_hits++;
            else if (if_req_i) begin
              m_misses++;
              m_fill_addr = {tg, idx, 4'b0};
              m_fill_flushed = 1'b0;
              m_phase = P_WAIT_MEM;
            end
          end
          P_WAIT_MEM: begin
            if (flush_i) m_fill_flushed = 1'b1;
            if (mem_done_i) begin
              fidx = m_fill_addr[9:4];
              ml[fidx] = mem_data_i;
              mt[fidx] = m_fill_addr[31:10];
              mv[fidx] = !m_fill_flushed;
              m_phase = P_RESUME;
            end
          end
          default: m_phase = P_IDLE;
        endcase
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_miss(input string name, input logic [31:0] a);
    if_req_i = 1'b1; if_addr_i = a;
    #1;
    chk(name, if_stall_o, 1);
  endtask

  // Request a, let the fill take lat REFILL cycles, optionally flush or move
  // the fetch address mid-fill; returns in IDLE with the request dropped.
  task automatic fill(input logic [31:0] a, input logic [127:0] d, input int lat,
                      input bit flush_mid, input logic [31:0] alt);
    int n = 0;
    if_req_i = 1'b1; if_addr_i = a;
    tick();
    while (!mem_read_o && n < 8) begin tick(); n++; end
    chk("fill_start", mem_read_o, 1);
    chk("fill_addr", mem_addr_o, {a[31:4], 4'b0});
    if (mem_read_o) begin
      if_addr_i = alt;
      if (flush_mid) flush_i = 1'b1;
      repeat (lat - 1) begin tick(); flush_i = 1'b0; end
      mem_done_i = 1'b1; mem_data_i = d;
      tick();
      mem_done_i = 1'b0; flush_i = 1'b0; mem_data_i = '0;
      if_req_i = 1'b0;
      tick();
    end else begin
      if_req_i = 1'b0;
    end
  endtask

  localparam logic [127:0] L10 = {32'h3333_0010, 32'h2222_0010, 32'hDEAD_BEEF, 32'h1111_0010};
  localparam logic [127:0] L00 = {32'hA3A3_0000, 32'hA2A2_0000, 32'hA1A1_0000, 32'hA0A0_0000};
  localparam logic [127:0] L400 = {32'hB3B3_0400, 32'hB2B2_0400, 32'hB1B1_0400, 32'hB0B0_0400};
  localparam logic [127:0] L20 = {32'hC3C3_0020, 32'hC2C2_0020, 32'hC1C1_0020, 32'hC0C0_0020};
  localparam logic [127:0] L30 = {32'hD3D3_0030, 32'hD2D2_0030, 32'hD1D1_0030, 32'hD0D0_0030};
  localparam logic [127:0] L50 = {32'hE3E3_0050, 32'hE2E2_0050, 32'hE1E1_0050, 32'hE0E0_0050};
  localparam logic [127:0] L60 = {32'hF3F3_0060, 32'hF2F2_0060, 32'hF1F1_0060, 32'hF0F0_0060};
  localparam logic [127:0] L40 = {32'h4343_0040, 32'h4242_0040, 32'h4141_0040, 32'h4040_0040};

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin : stimulus
    int s0;
    logic [31:0] exp_h, exp_m;
    rst_n = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h10;
    flush_i = 1'b0; mem_done_i = 1'b0; mem_data_i = '0;
    repeat (2) tick();
    // reset state with a request pending
    chk("rst_stall", if_stall_o, 0);
    chk("rst_read", mem_read_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_inst", if_inst_o, 0);

    // cold miss on 0x10, memory answers in the third REFILL cycle
    rst_n = 1'b1;
    s0 = stall_cycles;
    #1;
    chk("cold_stall", if_stall_o, 1);
    tick();
    chk("cold_read", mem_read_o, 1);
    chk("cold_addr", mem_addr_o, 32'h10);
    tick();
    tick();
    mem_done_i = 1'b1; mem_data_i = L10;
    tick();
    mem_done_i = 1'b0; mem_data_i = '0;
    chk("cold_read_drop", mem_read_o, 0);
    chk("cold_resume_stall", if_stall_o, 1);
    tick();
    chk("cold_hit_stall", if_stall_o, 0);
    chk("cold_hit_w0", if_inst_o, 32'h1111_0010);
    if_addr_i = 32'h14;
    #1;
    chk("cold_hit_w1", if_inst_o, 32'hDEAD_BEEF);
    chk("cold_stall_total", stall_cycles - s0, 5);
    tick();
    chk("cold_no_refetch", mem_read_o, 0);
    if_req_i = 1'b0;
    #1;
    chk("noreq_stall", if_stall_o, 0);
    chk("noreq_inst", if_inst_o, 0);

    // conflict miss on index 0
    fill(32'h000, L00, 2, 1'b0, 32'h000);
    if_req_i = 1'b1; if_addr_i = 32'h008;
    #1;
    chk("conf_hit0_w2", if_inst_o, 32'hA2A2_0000);
    expect_miss("conf_miss_400", 32'h400);
    fill(32'h400, L400, 1, 1'b0, 32'h400);
    expect_miss("conf_remiss_000", 32'h000);
    fill(32'h000, L00, 4, 1'b0, 32'h000);

    // flush in IDLE, then a request in the same cycle as a flush
    fill(32'h20, L20, 2, 1'b0, 32'h20);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    expect_miss("flush_miss_20", 32'h20);
    tick();
    chk("flush_refill_read", mem_read_o, 1);
    fill(32'h20, L20, 2, 1'b0, 32'h20);
    if_req_i = 1'b1; if_addr_i = 32'h20; flush_i = 1'b1;
    #1;
    chk("flush_same_cycle_miss", if_stall_o, 1);
    tick();
    flush_i = 1'b0;
    fill(32'h20, L20, 2, 1'b0, 32'h20);

    // flush while the 0x30 fill is outstanding
    fill(32'h30, L30, 3, 1'b1, 32'h30);
    expect_miss("flush_mid_miss_30", 32'h30);
    fill(32'h30, L30, 2, 1'b0, 32'h30);
    if_req_i = 1'b1; if_addr_i = 32'h3C;
    #1;
    chk("refill_30_w3", if_inst_o, 32'hD3D3_0030);

    // fetch address moves to 0x60 during the 0x50 fill
    fill(32'h50, L50, 3, 1'b0, 32'h60);
    if_req_i = 1'b1;
    #1;
    chk("readdr_miss_60", if_stall_o, 1);
    fill(32'h60, L60, 2, 1'b0, 32'h60);
    if_req_i = 1'b1; if_addr_i = 32'h50;
    #1;
    chk("readdr_line50_w0", if_inst_o, 32'hE0E0_0050);
    if_addr_i = 32'h68;
    #1;
    chk("line60_w2", if_inst_o, 32'hF2F2_0060);

    // stray mem_done_i in IDLE is ignored
    if_req_i = 1'b0; mem_done_i = 1'b1; mem_data_i = {4{32'h5555_AAAA}};
    tick();
    mem_done_i = 1'b0; mem_data_i = '0;
    if_req_i = 1'b1; if_addr_i = 32'h6C;
    #1;
    chk("stray_done_w3", if_inst_o, 32'hF3F3_0060);

    // reset in the middle of a fill
    if_addr_i = 32'h70;
    tick();
    chk("rstmid_read_before", mem_read_o, 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_read", mem_read_o, 0);
    chk("rstmid_stall", if_stall_o, 0);
    tick();
    if_req_i = 1'b0; rst_n = 1'b1;
    tick();
    mem_done_i = 1'b1; mem_data_i = L40;
    tick();
    mem_done_i = 1'b0; mem_data_i = '0;
    expect_miss("rstmid_invalid_70", 32'h70);
    expect_miss("rstmid_invalid_60", 32'h60);
    if_req_i = 1'b0;
    tick();

    // statistics: one miss, then three hits on the same line
    fill(32'h40, L40, 2, 1'b0, 32'h40);
    if_req_i = 1'b1;
    if_addr_i = 32'h40; tick();
    if_addr_i = 32'h44; tick();
    if_addr_i = 32'h48; tick();
    if_req_i = 1'b0;
`ifdef ICACHE_STATS_EN
    exp_h = 32'd3; exp_m = 32'd1;
`else
    exp_h = 32'd0; exp_m = 32'd0;
`endif
    chk("stats_hits", hit_cnt_o, exp_h);
    chk("stats_misses", miss_cnt_o, exp_m);

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_i_cache
`default_nettype wire

// File: doc/i_cache.md
I_CACHE -- requirements
Module: i_cache

Interface
REQ-001 Parameters SHALL be:
- ADDR_WIDTH, 32, fetch address width.
- DATA_WIDTH, 32, instruction width.
- SELECT_WIDTH, 4, line-offset bits; one line is 16 B, i.e. 4 words = 128 bits.
- INDEX_WIDTH, 6, line-index bits; 64 lines.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- if_req_i  in  1  fetch request.
- if_addr_i  in  ADDR_WIDTH  fetch byte address.
- if_inst_o  out  DATA_WIDTH  fetched instruction.
- if_stall_o  out  1  fetch not served this cycle.
- flush_i  in  1  invalidate all lines (fence.i).
- mem_read_o  out  1  line-fill request to memory.
- mem_addr_o  out  ADDR_WIDTH  line-aligned fill address.
- mem_data_i  in  128  fill data; word k at bits [32k+31:32k].
- mem_done_i  in  1  one-cycle pulse: mem_data_i valid.
- hit_cnt_o  out  32  hit count (ICACHE_STATS_EN only).
- miss_cnt_o  out  32  miss count (ICACHE_STATS_EN only).

Function
REQ-003 Organisation SHALL be direct-mapped, using these address fields:
- offset = addr[3:0]; word select = addr[3:2]; addr[1:0] ignored.
- index = addr[9:4].
- tag = addr[31:10].
REQ-004 Storage SHALL be one valid bit, one 22-bit tag and one 128-bit line per index.
REQ-005 FSM states SHALL be IDLE, REFILL, RESUME.
REQ-006 Hit in IDLE: if_req_i=1, valid set and tag equal.
- if_inst_o SHALL carry the selected word combinationally in the same cycle.
- if_stall_o SHALL be 0.
REQ-007 Miss in IDLE: if_req_i=1 and the line is invalid or the tag differs.
- if_stall_o SHALL be 1 in the same cycle.
- Next state SHALL be REFILL.
- The tag and index SHALL be latched.
REQ-008 REFILL:
- mem_read_o SHALL be 1 and mem_addr_o SHALL equal {latched tag, latched index, 4'b0}; both held stable until mem_done_i.
- if_stall_o SHALL be 1.
REQ-009 On mem_done_i in REFILL:
- mem_data_i SHALL be written to the latched index, the tag stored and valid set.
- mem_read_o SHALL drop on the next edge.
- Next state SHALL be RESUME.
REQ-010 RESUME SHALL assert if_stall_o=1 for one cycle, then go to IDLE, where the re-lookup hits. Miss latency is therefore memory latency + 2 cycles.
REQ-011 If if_addr_i changes during REFILL, the fill SHALL still complete to the latched line, and the new address SHALL be looked up in IDLE.
REQ-012 If if_req_i=0, if_stall_o SHALL be 0, if_inst_o SHALL be 0, and no fill SHALL start.
REQ-013 flush_i in IDLE or RESUME SHALL clear all valid bits at the next edge. A request in the same cycle SHALL be treated as a miss.
REQ-014 flush_i during REFILL SHALL let the fill finish and write the data, but SHALL leave that line's valid bit clear.
REQ-015 A mem_done_i pulse outside REFILL SHALL be ignored.

Reset
REQ-016 While rst_n=0, asynchronously:
- state = IDLE.
- All valid bits = 0.
- mem_read_o = 0.
- mem_addr_o = 0.
- if_stall_o = 0.
- if_inst_o = 0.
- Counters = 0.
REQ-017 Tag and line storage SHALL need no reset.
REQ-018 A reset asserted mid-REFILL SHALL abandon the fill. A later mem_done_i SHALL be ignored per REQ-015.

Configuration
REQ-019 Macro ICACHE_STATS_EN:
- Defined: hit_cnt_o SHALL increment on each served hit (REQ-006), and miss_cnt_o SHALL increment once per IDLE→REFILL transition; both wrap modulo 2^32.
- Undefined: no counter logic, and both outputs SHALL be tied to 0.

Structure
REQ-020 The shared defines file SHALL hold:
- the FSM state encodings;
- the line width (128);
- the offset/index/tag field positions.
REQ-021 Submodule i_cache_array SHALL hold the valid/tag/line storage, with an asynchronous read port, a synchronous write port and a flush input. The FSM SHALL stay in i_cache.

Verification
REQ-022 Cold miss: reset, then request 0x0000_0010.
- mem_read_o=1 with mem_addr_o=0x0000_0010.
- mem_done_i after 3 cycles with word1=0xDEADBEEF.
- Then request 0x0000_0014 → if_inst_o=0xDEADBEEF, stall=0, and no new mem_read_o.
- Total stall for 0x10 = 5 cycles.
REQ-023 Conflict: fill 0x0000_0000, then request 0x0000_0400 (same index) → miss; after the fill, re-request 0x0000_0000 → miss.
REQ-024 Flush: fill 0x20, pulse flush_i, request 0x20 → miss and mem_read_o=1.
REQ-025 Flush during REFILL of 0x30 → fill completes, and the next request to 0x30 misses again.
REQ-026 Reset mid-REFILL: rst_n low while mem_read_o=1 → mem_read_o=0 immediately; a subsequent stray mem_done_i leaves all lines invalid.
REQ-027 With ICACHE_STATS_EN: 1 miss then 3 hits to the same line → miss_cnt_o=1, hit_cnt_o=3.
